cell_redraw_scheduler: RTL and testbench

//   Upstream feeder of the per-cell draw engine. Tracks, per grid cell, the last cursor/reveal/state

---
 rtl/cell_redraw_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_cell_redraw_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cell_redraw_scheduler.sv
// Sweeps the grid in raster order and issues one draw command per cell whose live
// cursor/reveal/state differs from the last drawn snapshot or is force-marked.
module cell_redraw_scheduler #(
    parameter int unsigned GRID_SIZE  = 3,
    parameter int unsigned GRID_BIT   = 4,
    parameter int unsigned STATE_SIZE = 4,
    parameter int unsigned CELL_PITCH = 9
) (
    input  logic                                     clock,
    input  logic                                     resetn,
    input  logic                                     full_redraw,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]           cursorGrid,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]           revealGrid,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    input  logic                                     cmd_ready,
    output logic                                     cmd_valid,
    output logic [7:0]                               cmd_x,
    output logic [6:0]                               cmd_y,
    output logic                                     cmd_border,
    output logic                                     cmd_content,
    output logic                                     cmd_cursor,
    output logic                                     cmd_reveal,
    output logic [STATE_SIZE-1:0]                    cmd_state,
    output logic                                     idle
);
    localparam int unsigned N     = GRID_SIZE * GRID_SIZE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {SCAN, ISSUE} state_t;

    state_t                  state_q, state_n;
    logic [GRID_BIT-1:0]     col_q, col_n, row_q, row_n;
    logic [N-1:0]            force_b_q, force_b_n, force_c_q, force_c_n;
    logic [N-1:0]            shadow_cursor_q, shadow_cursor_n;
    logic [N-1:0]            shadow_reveal_q, shadow_reveal_n;
    logic [STATE_SIZE-1:0]   shadow_state_q [N];
    logic [STATE_SIZE-1:0]   shadow_state_n [N];
    logic                    sweep_issued_q, sweep_issued_n;

    logic                    cmd_valid_n, cmd_border_n, cmd_content_n;
    logic                    cmd_cursor_n, cmd_reveal_n, idle_n;
    logic [7:0]              cmd_x_n;
    logic [6:0]              cmd_y_n;
    logic [STATE_SIZE-1:0]   cmd_state_n;

    logic [STATE_SIZE-1:0]   live_state [N];
    logic [IDX_W-1:0]        cell_k;
    logic                    bdirty_c, cdirty_c, last_col_c, last_row_c, advance_c;

    for (genvar g = 0; g < int'(N); g++) begin : g_unpack
        assign live_state[g] = states[g*STATE_SIZE +: STATE_SIZE];
    end

    // Cell index is mirrored: (col,row)=(0,0) maps to the top bit of the grids.
    assign cell_k     = IDX_W'((GRID_SIZE - 1 - col_q) + (GRID_SIZE - 1 - row_q) * GRID_SIZE);
    assign last_col_c = (col_q == GRID_BIT'(GRID_SIZE - 1));
    assign last_row_c = (row_q == GRID_BIT'(GRID_SIZE - 1));
    assign bdirty_c   = force_b_q[cell_k] | full_redraw
                      | (cursorGrid[cell_k] != shadow_cursor_q[cell_k]);
    assign cdirty_c   = force_c_q[cell_k] | full_redraw
                      | (revealGrid[cell_k] != shadow_reveal_q[cell_k])
                      | (live_state[cell_k] != shadow_state_q[cell_k]);

    always_comb begin
        state_n         = state_q;
        col_n           = col_q;
        row_n           = row_q;
        force_b_n       = force_b_q;
        force_c_n       = force_c_q;
        shadow_cursor_n = shadow_cursor_q;
        shadow_reveal_n = shadow_reveal_q;
        shadow_state_n  = shadow_state_q;
        sweep_issued_n  = sweep_issued_q;
        cmd_valid_n     = cmd_valid;
        cmd_x_n         = cmd_x;
        cmd_y_n         = cmd_y;
        cmd_border_n    = cmd_border;
        cmd_content_n   = cmd_content;
        cmd_cursor_n    = cmd_cursor;
        cmd_reveal_n    = cmd_reveal;
        cmd_state_n     = cmd_state;
        idle_n          = idle;
        advance_c       = 1'b0;

        case (state_q)
            SCAN: begin
                if (bdirty_c || cdirty_c) begin
                    cmd_valid_n    = 1'b1;
                    cmd_x_n        = 8'(col_q * CELL_PITCH);
                    cmd_y_n        = 7'(row_q * CELL_PITCH);
                    cmd_border_n   = bdirty_c;
                    cmd_content_n  = cdirty_c;
                    cmd_cursor_n   = cursorGrid[cell_k];
                    cmd_reveal_n   = revealGrid[cell_k];
                    cmd_state_n    = live_state[cell_k];
                    idle_n         = 1'b0;
                    sweep_issued_n = 1'b1;
                    state_n        = ISSUE;
                end else begin
                    advance_c = 1'b1;
                end
            end
            ISSUE: begin
                // The drawn snapshot, not the live value, becomes the new reference.
                if (cmd_ready) begin
                    cmd_valid_n             = 1'b0;
                    shadow_cursor_n[cell_k] = cmd_cursor;
                    shadow_reveal_n[cell_k] = cmd_reveal;
                    shadow_state_n[cell_k]  = cmd_state;
                    if (cmd_border)  force_b_n[cell_k] = 1'b0;
                    if (cmd_content) force_c_n[cell_k] = 1'b0;
                    advance_c               = 1'b1;
                    state_n                 = SCAN;
                end
            end
            default: state_n = SCAN;
        endcase

        if (advance_c) begin
            if (last_col_c && last_row_c) begin
                col_n = '0;
                row_n = '0;
                if (!sweep_issued_q && !full_redraw && (force_b_q == '0) && (force_c_q == '0))
                    idle_n = 1'b1;
                sweep_issued_n = 1'b0;
            end else if (last_col_c) begin
                col_n = '0;
                row_n = row_q + GRID_BIT'(1);
            end else begin
                col_n = col_q + GRID_BIT'(1);
            end
        end

        // Applied last so a same-cycle handshake clear cannot drop the force.
        if (full_redraw) begin
            force_b_n = '1;
            force_c_n = '1;
            idle_n    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= SCAN;
            col_q           <= '0;
            row_q           <= '0;
            force_b_q       <= '1;
            force_c_q       <= '1;
            shadow_cursor_q <= '0;
            shadow_reveal_q <= '0;
            shadow_state_q  <= '{default: '0};
            sweep_issued_q  <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_x           <= '0;
            cmd_y           <= '0;
            cmd_border      <= 1'b0;
            cmd_content     <= 1'b0;
            cmd_cursor      <= 1'b0;
            cmd_reveal      <= 1'b0;
            cmd_state       <= '0;
            idle            <= 1'b0;
        end else begin
            state_q         <= state_n;
            col_q           <= col_n;
            row_q           <= row_n;
            force_b_q       <= force_b_n;
            force_c_q       <= force_c_n;
            shadow_cursor_q <= shadow_cursor_n;
            shadow_reveal_q <= shadow_reveal_n;
            shadow_state_q  <= shadow_state_n;
            sweep_issued_q  <= sweep_issued_n;
            cmd_valid       <= cmd_valid_n;
            cmd_x           <= cmd_x_n;
            cmd_y           <= cmd_y_n;
            cmd_border      <= cmd_border_n;
            cmd_content     <= cmd_content_n;
            cmd_cursor      <= cmd_cursor_n;
            cmd_reveal      <= cmd_reveal_n;
            cmd_state       <= cmd_state_n;
            idle            <= idle_n;
        end
    end
endmodule

// File: tb/tb_cell_redraw_scheduler.sv
// Directed bench for cell_redraw_scheduler: raster full redraw, single-cell updates,
// ready stalls, mid-sweep full_redraw and reset during an outstanding command.
module tb_cell_redraw_scheduler;
    logic        clock = 1'b0;
    logic        resetn;
    logic        full_redraw;
    logic [8:0]  cursorGrid;
    logic [8:0]  revealGrid;
    logic [35:0] states;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic        cmd_border;
    logic        cmd_content;
    logic        cmd_cursor;
    logic        cmd_reveal;
    logic [3:0]  cmd_state;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    cell_redraw_scheduler dut (
        .clock       (clock),
        .resetn      (resetn),
        .full_redraw (full_redraw),
        .cursorGrid  (cursorGrid),
        .revealGrid  (revealGrid),
        .states      (states),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_border  (cmd_border),
        .cmd_content (cmd_content),
        .cmd_cursor  (cmd_cursor),
        .cmd_reveal  (cmd_reveal),
        .cmd_state   (cmd_state),
        .idle        (idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (idle !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    // Negative snapshot arguments mean "don't check"; consumes the command with ready=1.
    task automatic take(input string tag, input int x, input int y, input int b, input int c,
                        input int cur, input int rev, input int st);
        wait_cmd(tag);
        check({tag, "_x"}, 32'(cmd_x), 32'(x));
        check({tag, "_y"}, 32'(cmd_y), 32'(y));
        check({tag, "_border"}, 32'(cmd_border), 32'(b));
        check({tag, "_content"}, 32'(cmd_content), 32'(c));
        if (cur >= 0) check({tag, "_cursor"}, 32'(cmd_cursor), 32'(cur));
        if (rev >= 0) check({tag, "_reveal"}, 32'(cmd_reveal), 32'(rev));
        if (st >= 0)  check({tag, "_state"}, 32'(cmd_state), 32'(st));
        @(negedge clock);
    endtask

    initial begin
        resetn      = 1'b0;
        full_redraw = 1'b0;
        cursorGrid  = '0;
        revealGrid  = '0;
        states      = '0;
        cmd_ready   = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        check("rst_x", 32'(cmd_x), 32'd0);
        check("rst_border", 32'(cmd_border), 32'd0);
        resetn = 1'b1;

        // Power-up: every cell forced, raster order.
        for (int r = 0; r < 9; r++)
            take($sformatf("init%0d", r), (r % 3) * 9, (r / 3) * 9, 1, 1, 0, 0, 0);
        wait_idle("init");

        // Cursor-only change on (1,1).
        cursorGrid[4] = 1'b1;
        take("cur", 9, 9, 1, 0, 1, 0, 0);
        check("cur_idle_low", 32'(idle), 32'd0);
        wait_idle("cur");

        // Content-only change on (2,2).
        revealGrid[0] = 1'b1;
        states[3:0]   = 4'd3;
        take("rev", 18, 18, 0, 1, 0, 1, 3);
        wait_idle("rev");

        // Stall with ready low; live state change during the stall.
        cmd_ready     = 1'b0;
        cursorGrid[8] = 1'b1;
        wait_cmd("stall");
        check("stall_x", 32'(cmd_x), 32'd0);
        check("stall_border", 32'(cmd_border), 32'd1);
        check("stall_content", 32'(cmd_content), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("stall_hold%0d", i),
                  32'({cmd_valid, cmd_x, cmd_y, cmd_border, cmd_content, cmd_cursor, cmd_reveal, cmd_state}),
                  32'({1'b1, 8'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0}));
            if (i == 1) states[35:32] = 4'd5;
        end
        cmd_ready = 1'b1;
        @(negedge clock);
        check("stall_release", 32'(cmd_valid), 32'd0);
        take("reissue", 0, 0, 0, 1, 1, 0, 5);
        wait_idle("reissue");

        // Scanner sits at raster cell 0 on the first idle negedge; pulse at cell 5.
        repeat (5) @(negedge clock);
        full_redraw = 1'b1;
        @(negedge clock);
        full_redraw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            int r;
            r = (5 + i) % 9;
            take($sformatf("fr%0d", r), (r % 3) * 9, (r / 3) * 9, 1, 1, -1, -1, -1);
        end
        wait_idle("fr");

        // Reset while a command is stalled.
        cmd_ready     = 1'b0;
        cursorGrid[8] = 1'b0;
        wait_cmd("rstmid");
        check("rstmid_x", 32'(cmd_x), 32'd0);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("rstmid_valid_drop", 32'(cmd_valid), 32'd0);
        check("rstmid_idle", 32'(idle), 32'd0);
        cmd_ready = 1'b1;
        for (int r = 0; r < 9; r++)
            take($sformatf("post%0d", r), (r % 3) * 9, (r / 3) * 9, 1, 1, -1, -1, -1);
        wait_idle("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
